ahb_dma_responder: RTL

AHB-Lite subordinate that answers the BIO DMA master port: it is the responder end of the `htrans/haddr/hwdata` bus that `bio_bdma` drives. The block is a word-addressed SRAM model with programmable wait states and error responses, plus transfer and error counters. It serves as the DMA target in subsystem simulation and as a small on-chip scratch buffer.

---
 rtl/ahb_resp_pkg.sv | 25 ++
 rtl/ahb_resp_bytemask.sv | 28 ++
 rtl/ahb_dma_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ahb_resp_pkg.sv
// Shared types and encodings for the AHB-Lite DMA responder.
package ahb_resp_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_resp_bytemask.sv
// Byte-lane mask and alignment check for a 32-bit AHB transfer.
module ahb_resp_bytemask
  import ahb_resp_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       misalign
);

  always_comb begin
    mask     = '0;
    misalign = 1'b0;
    case (size)
      HSIZE_BYTE: mask = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        mask     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        mask     = '1;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_dma_responder.sv
// AHB-Lite SRAM responder with programmable wait states, error responses
// and transfer/error counters.
module ahb_dma_responder
  import ahb_resp_pkg::*;
#(
  parameter int unsigned       AW    = 32,
  parameter int unsigned       DW    = 32,
  parameter int unsigned       UW    = 4,
  parameter int unsigned       DEPTH = 256,
  parameter logic [AW-1:0]     BASE  = '0,
  parameter int unsigned       WAIT  = 0
) (
  input  logic          aclk,
  input  logic          reset_n,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic          hmasterlock,
  input  logic [3:0]    hprot,
  input  logic [UW-1:0] hauser,
  input  logic [DW-1:0] hwdata,
  input  logic [UW-1:0] hwuser,
  input  logic          hreadym,
  output logic          hreadyout,
  output logic          hresp,
  output logic [DW-1:0] hrdata,
  output logic [UW-1:0] hruser,
  output logic [15:0]   xfer_cnt,
  output logic [7:0]    err_cnt
);

  localparam int unsigned IDXW     = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

  resp_state_e     state;
  logic [3:0]      wcnt;
  logic [IDXW-1:0] idx_q;
  logic [1:0]      lo_q;
  logic [2:0]      size_q;
  logic            write_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            accept;
  logic            bad;
  logic            done;
  logic [AW-1:0]   offset;
  logic [3:0]      mask_a;
  logic [3:0]      mask_q;
  logic            misalign_a;
  logic            misalign_q;

  ahb_resp_bytemask u_mask_addr (
    .size     (hsize),
    .addr_lo  (haddr[1:0]),
    .mask     (mask_a),
    .misalign (misalign_a)
  );

  ahb_resp_bytemask u_mask_data (
    .size     (size_q),
    .addr_lo  (lo_q),
    .mask     (mask_q),
    .misalign (misalign_q)
  );

  assign accept = hsel & hreadym &
                  (htrans_e'(htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
  // Power-of-2 depth: any offset bit above the word index means out of range,
  // including addresses below BASE, which wrap to a huge offset.
  assign offset = haddr - BASE;
  assign bad    = (hsize > HSIZE_WORD) | misalign_a | (|offset[AW-1:IDXW+2]);
  assign done   = (state == ST_DATA) && (wcnt == '0);

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      idx_q     <= '0;
      lo_q      <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      xfer_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      if (done) xfer_cnt <= xfer_cnt + 16'd1;

      if (state == ST_DATA && wcnt != '0) begin
        wcnt      <= wcnt - 4'd1;
        hreadyout <= (wcnt == 4'd1);
      end else if (state == ST_ERR1) begin
        state     <= ST_ERR2;
        hreadyout <= 1'b1;
        hresp     <= HRESP_ERROR;
      end else if (accept) begin
        idx_q   <= haddr[IDXW+1:2];
        lo_q    <= haddr[1:0];
        size_q  <= hsize;
        write_q <= hwrite;
        if (bad) begin
          state     <= ST_ERR1;
          hreadyout <= 1'b0;
          hresp     <= HRESP_ERROR;
          if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end else begin
          state     <= ST_DATA;
          wcnt      <= WAIT_CNT;
          hreadyout <= (WAIT_CNT == '0);
          hresp     <= HRESP_OKAY;
        end
      end else begin
        state     <= ST_IDLE;
        hreadyout <= 1'b1;
        hresp     <= HRESP_OKAY;
      end
    end
  end

  // Contents survive reset; reset only cancels a pending commit via state.
  always_ff @(posedge aclk) begin
    if (done && write_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (done && !write_q) hrdata = mem[idx_q];
  end

  assign hruser = '0;

  logic unused;
  assign unused = ^{hburst, hmasterlock, hprot, hauser, hwuser,
                    offset[IDXW+1:0], mask_a, misalign_q};

endmodule
